bp_cce_lce_req_ingress: RTL

CCE-side ingress stage for LCE request messages; consumes what the LCE request handler emits after the coherence network delivers it. It buffers requests in a small FIFO, screens misrouted or malformed messages, and decodes the header into flat fields for the CCE control FSM. The CCE control FSM dequeues with valid->yumi.

---
 rtl/bp_cce_lce_req_ingress_pkg.sv | 88 ++++++++
 rtl/bp_cce_lce_req_ingress_fifo.sv | 56 +++++
 rtl/bp_cce_lce_req_ingress.sv | 123 ++++++++++++
 3 files changed

// File: rtl/bp_cce_lce_req_ingress_pkg.sv
// Shared types for the CCE LCE-request ingress path: bedrock request message
// layout, decoded-entry struct handed to the CCE control FSM, and FSM states.
package bp_cce_lce_req_ingress_pkg;

  localparam int paddr_width_p     = 40;
  localparam int cce_block_width_p = 512;
  localparam int lce_id_width_p    = 8;
  localparam int cce_id_width_p    = 6;
  localparam int lce_assoc_p       = 8;
  localparam int dword_width_p     = 64;

  localparam int lg_lce_assoc_lp       = $clog2(lce_assoc_p);
  localparam int block_offset_width_lp = $clog2(cce_block_width_p/8);

  typedef enum logic [3:0] {
    e_bedrock_req_rd     = 4'd0,
    e_bedrock_req_wr     = 4'd1,
    e_bedrock_req_uc_rd  = 4'd2,
    e_bedrock_req_uc_wr  = 4'd3,
    e_bedrock_req_uc_amo = 4'd4
  } bp_bedrock_req_type_e;

  // Encoding is log2 of the size in bytes
  typedef enum logic [2:0] {
    e_bedrock_msg_size_1   = 3'd0,
    e_bedrock_msg_size_2   = 3'd1,
    e_bedrock_msg_size_4   = 3'd2,
    e_bedrock_msg_size_8   = 3'd3,
    e_bedrock_msg_size_16  = 3'd4,
    e_bedrock_msg_size_32  = 3'd5,
    e_bedrock_msg_size_64  = 3'd6,
    e_bedrock_msg_size_128 = 3'd7
  } bp_bedrock_msg_size_e;

  typedef enum logic [0:0] {
    e_bedrock_req_excl     = 1'b0,
    e_bedrock_req_non_excl = 1'b1
  } bp_bedrock_req_non_excl_e;

  typedef struct packed {
    logic [cce_id_width_p-1:0]  dst_id;
    logic [lce_id_width_p-1:0]  src_id;
    logic [lg_lce_assoc_lp-1:0] lru_way_id;
    bp_bedrock_req_non_excl_e   non_exclusive;
  } bp_bedrock_lce_req_payload_s;

  typedef struct packed {
    bp_bedrock_req_type_e        msg_type;
    logic [paddr_width_p-1:0]    addr;
    bp_bedrock_msg_size_e        size;
    bp_bedrock_lce_req_payload_s payload;
  } bp_bedrock_lce_req_header_s;

  typedef struct packed {
    bp_bedrock_lce_req_header_s   header;
    logic [cce_block_width_p-1:0] data;
  } bp_bedrock_lce_req_msg_s;

  localparam int lce_req_msg_width_lp = $bits(bp_bedrock_lce_req_msg_s);

  // Size encoding of one full cache block
  localparam bp_bedrock_msg_size_e block_size_lp =
    bp_bedrock_msg_size_e'(3'(block_offset_width_lp));

  // Flat, pre-decoded request as seen by the CCE control FSM
  typedef struct packed {
    logic [lce_id_width_p-1:0]  lce_id;
    logic [paddr_width_p-1:0]   addr;
    logic                       cached;
    logic                       write;
    logic                       non_excl;
    logic [lg_lce_assoc_lp-1:0] lru_way;
    bp_bedrock_msg_size_e       size;
    logic [dword_width_p-1:0]   uc_data;
    logic                       size_err;
  } bp_cce_lce_req_entry_s;

  // Ingress FSM states
  localparam logic [0:0] e_reset = 1'b0;
  localparam logic [0:0] e_ready = 1'b1;

  // True for the request types the CCE handles; anything else is dropped
  function automatic logic is_supported_req(bp_bedrock_req_type_e t);
    return (t == e_bedrock_req_rd) || (t == e_bedrock_req_wr)
        || (t == e_bedrock_req_uc_rd) || (t == e_bedrock_req_uc_wr);
  endfunction

endpackage

// File: rtl/bp_cce_lce_req_ingress_fifo.sv
// Small 1-read/1-write FIFO with valid->yumi dequeue and ready->valid enqueue.
// Head data comes straight from storage, so there is no enqueue-to-output bypass.
module bsg_fifo_1r1w_small #(
  parameter int width_p = 8,
  parameter int els_p   = 2
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int ptr_width_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_width_lp = $clog2(els_p+1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p-1);
  localparam logic [cnt_width_lp-1:0] full_cnt_lp = cnt_width_lp'(els_p);

  logic [width_p-1:0]      mem_r [els_p];
  logic [ptr_width_lp-1:0] rptr_r, wptr_r;
  logic [cnt_width_lp-1:0] cnt_r;
  logic                    enq, deq;

  function automatic logic [ptr_width_lp-1:0] ptr_next(logic [ptr_width_lp-1:0] p);
    return (p == last_ptr_lp) ? '0 : p + 1'b1;
  endfunction

  assign ready_o = (cnt_r != full_cnt_lp);
  assign v_o     = (cnt_r != '0);
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i & v_o;
  assign data_o  = mem_r[rptr_r];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rptr_r <= '0;
      wptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (enq) wptr_r <= ptr_next(wptr_r);
      if (deq) rptr_r <= ptr_next(rptr_r);
      if (enq & ~deq)      cnt_r <= cnt_r + 1'b1;
      else if (~enq & deq) cnt_r <= cnt_r - 1'b1;
    end
  end

  // Storage write; contents need no reset since occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (enq) mem_r[wptr_r] <= data_i;
  end

endmodule

// File: rtl/bp_cce_lce_req_ingress.sv
// CCE-side ingress for LCE requests: screens misrouted/unsupported messages,
// decodes the header at enqueue and buffers decoded entries for the CCE FSM.
//
// state   | meaning
// --------+---------------------------------------------------------------
// e_reset | held while reset_n_i=0 and for the first cycle after release
// e_ready | steady state; accepts whenever the FIFO has room
module bp_cce_lce_req_ingress
  import bp_cce_lce_req_ingress_pkg::*;
#(
  parameter int els_p            = 2,
  parameter int drop_cnt_width_p = 8
) (
  input  logic                            clk_i,
  input  logic                            reset_n_i,
  input  logic [cce_id_width_p-1:0]       cce_id_i,
  input  logic [lce_req_msg_width_lp-1:0] lce_req_i,
  input  logic                            lce_req_v_i,
  output logic                            lce_req_ready_o,
  output logic                            req_v_o,
  input  logic                            req_yumi_i,
  output logic [lce_id_width_p-1:0]       req_lce_id_o,
  output logic [paddr_width_p-1:0]        req_addr_o,
  output logic                            req_cached_o,
  output logic                            req_write_o,
  output logic                            req_non_excl_o,
  output logic [lg_lce_assoc_lp-1:0]      req_lru_way_o,
  output logic [2:0]                      req_size_o,
  output logic [dword_width_p-1:0]        req_uc_data_o,
  output logic                            req_size_err_o,
  output logic                            err_o,
  output logic [drop_cnt_width_p-1:0]     drop_count_o
);

  localparam int entry_width_lp = $bits(bp_cce_lce_req_entry_s);

  logic [0:0]                  state_r;
  bp_bedrock_lce_req_msg_s     msg;
  bp_cce_lce_req_entry_s       entry_in, entry_out;
  logic [entry_width_lp-1:0]   fifo_data_out;
  logic                        fifo_ready, accept, drop, enq, deq;
  logic                        unused;

  assign msg = lce_req_i;

  assign lce_req_ready_o = (state_r == e_ready) & fifo_ready;
  assign accept          = lce_req_v_i & lce_req_ready_o;
  assign drop            = accept & ((msg.header.payload.dst_id != cce_id_i)
                                     | ~is_supported_req(msg.header.msg_type));
  assign enq             = accept & ~drop;
  assign deq             = req_yumi_i & req_v_o;

  // Only the low dword of the data payload is carried forward
  assign unused = ^msg.data[cce_block_width_p-1:dword_width_p];

  // Single transition out of reset
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) state_r <= e_reset;
    else            state_r <= e_ready;
  end

  // Header decode into the flat entry stored in the FIFO
  always_comb begin
    entry_in          = '0;
    entry_in.lce_id   = msg.header.payload.src_id;
    entry_in.cached   = (msg.header.msg_type == e_bedrock_req_rd)
                      | (msg.header.msg_type == e_bedrock_req_wr);
    entry_in.write    = (msg.header.msg_type == e_bedrock_req_wr)
                      | (msg.header.msg_type == e_bedrock_req_uc_wr);
    entry_in.non_excl = (msg.header.msg_type == e_bedrock_req_rd)
                      & (msg.header.payload.non_exclusive == e_bedrock_req_non_excl);
    entry_in.addr     = entry_in.cached
                      ? {msg.header.addr[paddr_width_p-1:block_offset_width_lp],
                         {block_offset_width_lp{1'b0}}}
                      : msg.header.addr;
    entry_in.lru_way  = msg.header.payload.lru_way_id;
    entry_in.size     = msg.header.size;
    entry_in.uc_data  = msg.data[dword_width_p-1:0];
    entry_in.size_err = entry_in.cached & (msg.header.size != block_size_lp);
  end

  bsg_fifo_1r1w_small #(
    .width_p(entry_width_lp),
    .els_p  (els_p)
  ) fifo (
    .clk_i  (clk_i),
    .reset_i(~reset_n_i),
    .v_i    (enq),
    .ready_o(fifo_ready),
    .data_i (entry_in),
    .v_o    (req_v_o),
    .data_o (fifo_data_out),
    .yumi_i (deq)
  );

  assign entry_out      = fifo_data_out;
  assign req_lce_id_o   = entry_out.lce_id;
  assign req_addr_o     = entry_out.addr;
  assign req_cached_o   = entry_out.cached;
  assign req_write_o    = entry_out.write;
  assign req_non_excl_o = entry_out.non_excl;
  assign req_lru_way_o  = entry_out.lru_way;
  assign req_size_o     = entry_out.size;
  assign req_uc_data_o  = entry_out.uc_data;
  assign req_size_err_o = entry_out.size_err;

  // Sticky error flag and saturating drop counter
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      err_o        <= 1'b0;
      drop_count_o <= '0;
    end else if (drop) begin
      err_o <= 1'b1;
      if (drop_count_o != '1) drop_count_o <= drop_count_o + 1'b1;
    end
  end

  // Consuming an empty queue is a protocol violation by the CCE FSM
  always_ff @(posedge clk_i) begin
    if (reset_n_i) yumi_without_valid: assert (!(req_yumi_i && !req_v_o));
  end

endmodule
